// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (8N1 by default) that writes good bytes into a FIFO.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and the PARITY_ERRo output.
module uart_rx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                  CLKip,
   input  logic                  RSTi,
   input  logic                  RXi,
   input  logic                  FULLi,
   output logic [DATA_WIDTH-1:0] DATAo,
   output logic                  WEo,
   output logic                  FRAME_ERRo,
   output logic                  OVERRUNo,
`ifdef UART_RX_PARITY_EN
   output logic                  PARITY_ERRo,
`endif
   output logic                  BUSYo
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_WIDTH) + 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_divisor
         $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
      end
      if (DATA_WIDTH < 2) begin : g_bad_width
         $error("uart_rx: DATA_WIDTH must be at least 2");
      end
      if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
         $error("uart_rx: PARITY_ODD must be 0 or 1");
      end
   endgenerate

   logic                  rx_meta_q;
   logic                  rx_s_q;
   logic [2:0]            state_q,   state_d;
   logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,   shift_d;
   logic [DATA_WIDTH-1:0] data_q,    data_d;
   logic                  we_q,      we_d;
   logic                  fe_q,      fe_d;
   logic                  ovr_q,     ovr_d;
`ifdef UART_RX_PARITY_EN
   logic                  par_q,     par_d;
   logic                  pe_q,      pe_d;
   logic                  par_bad;

   assign par_bad = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
`endif

   // Synchroniser flops reset to 1 so a reset release on an idle line is not seen as a start edge.
   always_ff @(posedge CLKip or posedge RSTi) begin
      if (RSTi) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
         rx_meta_q <= RXi;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      we_d      = 1'b0;
      fe_d      = 1'b0;
      ovr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      pe_d      = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d   = S_START;
               clk_cnt_d = '0;
            end
         end

         S_START: begin
            if (clk_cnt_q == CNT_HALF) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (clk_cnt_q == CNT_FULL) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d   = S_PARITY;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (clk_cnt_q == CNT_FULL) begin
               clk_cnt_d = '0;
               par_d     = rx_s_q;
               state_d   = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
`endif

         // Leaving mid stop bit keeps half a bit of margin for the next start edge.
         S_STOP: begin
            if (clk_cnt_q == CNT_FULL) begin
               clk_cnt_d = '0;
               state_d   = S_IDLE;
               if (!rx_s_q) begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad) begin
                  pe_d    = 1'b1;
`endif
               end else if (FULLi) begin
                  ovr_d   = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  data_d  = shift_q;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         // A held-low line produces one framing error, then waits for idle.
         S_BREAK: begin
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLKip or posedge RSTi) begin
      if (RSTi) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         fe_q      <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         pe_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         we_q      <= we_d;
         fe_q      <= fe_d;
         ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
         pe_q      <= pe_d;
`endif
      end
   end

   assign DATAo      = data_q;
   assign WEo        = we_q;
   assign FRAME_ERRo = fe_q;
   assign OVERRUNo   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign PARITY_ERRo = pe_q;
`endif
   assign BUSYo      = (state_q != S_IDLE);

endmodule
